// File: rtl/mem_stage_pipe.sv
// MEM stage: synchronous-read data RAM with byte/half/word access and a
// one-entry valid/ready MEM/WB output register.
module mem_stage_pipe #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 32,
   parameter int DEPTH  = 1024,
   parameter int RD_W   = 5
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic              in_mem_we,
   input  logic              in_mem_re,
   input  logic [1:0]        in_size,
   input  logic              in_unsigned,
   input  logic [ADDR_W-1:0] in_alu_res,
   input  logic [DATA_W-1:0] in_memdata,
   input  logic [RD_W-1:0]   in_rd_addr,
   input  logic              in_reg_en,
   input  logic              in_wb_sel,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_mem_data,
   output logic [ADDR_W-1:0] out_alu_res,
   output logic [RD_W-1:0]   out_rd_addr,
   output logic              out_reg_en,
   output logic              out_wb_sel,
   output logic              out_misalign
);

   localparam int NB = DATA_W / 8;
   localparam int AW = $clog2(DEPTH);

   logic [DATA_W-1:0] mem [DEPTH];

   logic              valid_q, valid_d;
   logic [ADDR_W-1:0] alu_q;
   logic [RD_W-1:0]   rd_q;
   logic              reg_en_q;
   logic              wb_sel_q;
   logic              mis_q;
   logic [DATA_W-1:0] rdata_q;
   logic [1:0]        off_q;
   logic [1:0]        size_q;
   logic              uns_q;
   logic              load_q;

   logic              accept;
   logic              misalign;
   logic [AW-1:0]     widx;
   logic [NB-1:0]     be;
   logic [DATA_W-1:0] wdata;

   // Sign/zero extension of the lane picked by the stored offset
   function automatic logic [DATA_W-1:0] fmt_load(
      input logic [DATA_W-1:0] w,
      input logic [1:0]        off,
      input logic [1:0]        sz,
      input logic              uns
   );
      logic [7:0]  b;
      logic [15:0] h;
      b = w[{off, 3'b000} +: 8];
      h = off[1] ? w[31:16] : w[15:0];
      case (sz)
         2'd0:    fmt_load = {{(DATA_W-8){~uns & b[7]}}, b};
         2'd1:    fmt_load = {{(DATA_W-16){~uns & h[15]}}, h};
         default: fmt_load = w;
      endcase
   endfunction

   assign in_ready = rst_n & (~valid_q | out_ready);
   assign accept   = in_valid & in_ready;
   assign widx     = in_alu_res[2 +: AW];

   always_comb begin
      misalign = 1'b0;
      be       = '0;
      wdata    = in_memdata;
      case (in_size)
         2'd0: begin
            be[in_alu_res[1:0]] = 1'b1;
            wdata               = {NB{in_memdata[7:0]}};
         end
         2'd1: begin
            misalign = in_alu_res[0];
            be       = in_alu_res[1] ? 4'b1100 : 4'b0011;
            wdata    = {(NB/2){in_memdata[15:0]}};
         end
         default: begin
            misalign = |in_alu_res[1:0];
            be       = '1;
         end
      endcase
      if (!(in_mem_we | in_mem_re)) misalign = 1'b0;
   end

   always_comb begin
      valid_d = valid_q;
      if (accept)         valid_d = 1'b1;
      else if (out_ready) valid_d = 1'b0;
   end

   // RAM array is not reset; writes gated by accept, which is low in reset
   always_ff @(posedge clk) begin
      if (accept && in_mem_we && !misalign) begin
         for (int i = 0; i < NB; i++) begin
            if (be[i]) mem[widx][i*8 +: 8] <= wdata[i*8 +: 8];
         end
      end
   end

   // MEM/WB output register
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         valid_q  <= 1'b0;
         alu_q    <= '0;
         rd_q     <= '0;
         reg_en_q <= 1'b0;
         wb_sel_q <= 1'b0;
         mis_q    <= 1'b0;
         rdata_q  <= '0;
         off_q    <= '0;
         size_q   <= '0;
         uns_q    <= 1'b0;
         load_q   <= 1'b0;
      end else begin
         valid_q <= valid_d;
         if (accept) begin
            alu_q    <= in_alu_res;
            rd_q     <= in_rd_addr;
            reg_en_q <= in_reg_en & ~misalign;
            wb_sel_q <= in_wb_sel;
            mis_q    <= misalign;
            off_q    <= in_alu_res[1:0];
            size_q   <= in_size;
            uns_q    <= in_unsigned;
            load_q   <= in_mem_re & ~misalign;
            if (in_mem_re && !misalign) rdata_q <= mem[widx];
         end
      end
   end

   assign out_valid    = valid_q;
   assign out_alu_res  = alu_q;
   assign out_rd_addr  = rd_q;
   assign out_reg_en   = reg_en_q;
   assign out_wb_sel   = wb_sel_q;
   assign out_misalign = mis_q;
   assign out_mem_data = load_q ? fmt_load(rdata_q, off_q, size_q, uns_q) : '0;

endmodule

// File: doc/mem_stage_pipe.md
Name: mem_stage_pipe

Overview:
- Parametrised successor to the single-cycle data-memory stage. Sits between EX/MEM and WB.
- Contains a synchronous-read data RAM and supports byte, halfword and word loads and stores, with sign or zero extension on loads.
- Drives a valid/ready registered MEM/WB output, so writeback stalls propagate back to EX.
- Flags misaligned accesses instead of corrupting memory.

Parameters:
- DATA_W, 32: datapath width. Must be 32; byte lanes are DATA_W/8.
- ADDR_W, 32: width of in_alu_res, which is used as the byte address.
- DEPTH, 1024: RAM depth in DATA_W words. Must be a power of two. Word index = in_alu_res[2 +: log2(DEPTH)].
- RD_W, 5: destination register address width.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  synchronous reset, active low.
- in_valid  in  1  EX/MEM entry present.
- in_ready  out  1  stage can accept this cycle.
- in_mem_we  in  1  entry is a store.
- in_mem_re  in  1  entry is a load. in_mem_we and in_mem_re are never both 1.
- in_size  in  2  access size: 0 = byte, 1 = half, 2 = word; 3 is treated as word.
- in_unsigned  in  1  load zero-extends when 1, sign-extends when 0.
- in_alu_res  in  ADDR_W  address, or ALU result passed through.
- in_memdata  in  DATA_W  store data, right-aligned.
- in_rd_addr  in  RD_W  destination register.
- in_reg_en  in  1  register write enable.
- in_wb_sel  in  1  1 = writeback selects memory data.
- out_valid  out  1  MEM/WB entry present.
- out_ready  in  1  WB can consume the entry.
- out_mem_data  out  DATA_W  formatted load data; 0 for non-loads.
- out_alu_res  out  ADDR_W  registered in_alu_res.
- out_rd_addr  out  RD_W  registered in_rd_addr.
- out_reg_en  out  1  registered in_reg_en, forced to 0 on misalign.
- out_wb_sel  out  1  registered in_wb_sel.
- out_misalign  out  1  the entry was a misaligned load or store.

Behaviour:
- Reset: while rst_n = 0 at an edge:
  - out_valid, out_alu_res, out_rd_addr, out_reg_en, out_wb_sel and out_misalign go to 0.
  - The held read word and the stored offset/size go to 0, so out_mem_data = 0.
  - in_ready = 0 combinationally while rst_n = 0, so no store is written during reset.
  - RAM contents are not reset.
  - Reset mid-stall discards the held entry.
- in_ready = rst_n & (!out_valid | out_ready). This is a one-entry output register with zero-bubble pass-through.
- Accept = in_valid & in_ready. On an accept edge:
  - All out_* control fields are captured.
  - out_valid <= 1.
  - The byte offset (addr[1:0]), size, unsigned flag and the load flag are stored.
- No accept while out_valid & out_ready: out_valid <= 0 at the edge.
- No accept and out_ready = 0: all outputs hold.
- Misalign conditions: half with addr[0] = 1, or word with addr[1:0] != 0. On misalign:
  - No RAM write occurs.
  - out_misalign = 1 and out_reg_en = 0.
  - out_mem_data = 0.
- Stores (accepted, aligned): the RAM is written at the accept edge with byte enables.
  - Byte: lane addr[1:0] gets in_memdata[7:0].
  - Half: lanes {addr[1],0} and {addr[1],1} get in_memdata[15:0].
  - Word: all four lanes.
- Loads: the RAM word at the word index is read at the accept edge into the held read word.
  - The held read word updates only on an accepted load, so it is stable through stalls.
- out_mem_data is combinational from the held word:
  - The byte or half is selected by the stored offset, then zero- or sign-extended per the stored unsigned flag.
  - A word load is passed through unchanged.
- Latency and throughput: the result is visible 1 cycle after accept. Throughput is 1 entry per cycle when out_ready = 1.
- Store followed by a load to the same word on the next accept sees the new data; there is no bypass need because the write completes at the earlier edge.
- Address bits above 2 + log2(DEPTH) are ignored, so addresses wrap modulo DEPTH×4 bytes.
- Non-memory entries (in_mem_we = in_mem_re = 0) pass through with out_mem_data = 0 and out_misalign = 0.

Test Plan:
1. Reset: hold rst_n = 0 for 3 cycles with in_valid = 1 and a store to 0x10 -> out_valid = 0, in_ready = 0, and a later word load of 0x10 returns its pre-reset value.
2. Sub-word store/load: word store 0x11223344 to 0x20, then byte store 0xAB to 0x21:
   - Word load 0x20 -> 0x1122AB44.
   - Signed byte load 0x21 -> 0xFFFFFFAB.
   - Unsigned half load 0x22 -> 0x00001122.
3. Back-to-back: store 0xDEADBEEF to 0x40 in cycle n, word load 0x40 in cycle n+1 -> out_mem_data = 0xDEADBEEF in cycle n+2, out_valid continuous.
4. Stall: accept a load of 0x40, hold out_ready = 0 for 4 cycles while in_valid = 1 -> in_ready = 0, outputs and out_mem_data are stable. Raise out_ready -> the next entry is accepted in the same cycle.
5. Misalign: word store 0xFFFFFFFF to 0x42 -> out_misalign = 1, out_reg_en = 0, and the word at 0x40 is unchanged. A half load from 0x41 behaves the same way.
6. Wrap: with DEPTH = 1024, store 0x5A5A5A5A to 0x1000 -> a word load of 0x0000 returns 0x5A5A5A5A.
